// File: rtl/lisa_lsu_hs.sv
// rtl/lisa_lsu_hs.sv - LISA load/store unit with handshaked data-memory port
//
// Purpose: accepts one load/store at a time from the execute stage, checks
// alignment, drives a word-addressed memory port with byte strobes, extracts
// and extends load data, and returns a one-cycle response. A hung memory
// access is aborted after TIMEOUT cycles (0 disables the timeout).
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid/req_ready           request handshake from the core
//   req_load, req_store           access kind (both 0 = no-op, both 1 = error)
//   req_size, req_signed          0=byte 1=half 2=word 3=illegal; load extension
//   req_addr, req_wdata           byte address, right-justified store data
//   resp_valid/resp_data/resp_err single-cycle response to the core
//   mem_req/mem_addr/mem_we       memory access request (held during access)
//   mem_wdata/mem_wstrb           lane-replicated store data and byte strobes
//   mem_ack/mem_rdata             memory completion and read word

module lisa_lsu_hs #(
   parameter int ADDR_W  = 16,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_load,
   input  logic              req_store,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_data,
   output logic              resp_err,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_wstrb,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q;
   logic [1:0]          size_q;
   logic                signed_q, load_q, store_q;
   logic [31:0]         wdata_q;
   logic [CW-1:0]       cnt_q;
   logic [31:0]         resp_data_q, resp_data_d;
   logic                resp_err_q, resp_err_d;
   logic                req_bad, in_access, timeout_hit;
   logic [7:0]          rd_byte;
   logic [15:0]         rd_half;
   logic [31:0]         load_ext;
   logic                unused_addr_hi;

   // Only the low ADDR_W address bits reach the memory port.
   assign unused_addr_hi = ^req_addr[31:ADDR_W];

   assign req_bad = (req_size == 2'd3)
                 || (req_size == 2'd1 && req_addr[0])
                 || (req_size == 2'd2 && req_addr[1:0] != 2'b00)
                 || (req_load && req_store);

   assign in_access   = (state_q == ACCESS);
   // Counter holds the number of unacknowledged cycles already spent; this
   // cycle is the last one allowed when it equals TIMEOUT-1.
   assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

   // Load lane selection and extension from the registered request.
   assign rd_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
   assign rd_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

   always_comb begin
      load_ext = mem_rdata;
      case (size_q)
         2'd0:    load_ext = {{24{signed_q & rd_byte[7]}}, rd_byte};
         2'd1:    load_ext = {{16{signed_q & rd_half[15]}}, rd_half};
         default: load_ext = mem_rdata;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      resp_data_d = '0;
      resp_err_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (req_bad) begin
                  state_d    = RESP;
                  resp_err_d = 1'b1;
               end else if (!req_load && !req_store) begin
                  state_d = RESP;
               end else begin
                  state_d = ACCESS;
               end
            end
         end
         ACCESS: begin
            // An ack on the final timeout cycle still completes normally.
            if (mem_ack) begin
               state_d     = RESP;
               resp_data_d = load_q ? load_ext : 32'd0;
            end else if (timeout_hit) begin
               state_d    = RESP;
               resp_err_d = 1'b1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         size_q      <= '0;
         signed_q    <= 1'b0;
         load_q      <= 1'b0;
         store_q     <= 1'b0;
         wdata_q     <= '0;
         cnt_q       <= '0;
         resp_data_q <= '0;
         resp_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         // Response registers are only non-zero for the cycle spent in RESP.
         resp_data_q <= resp_data_d;
         resp_err_q  <= resp_err_d;
         if (state_q == IDLE) begin
            cnt_q <= '0;
            if (req_valid) begin
               addr_q   <= req_addr[ADDR_W-1:0];
               size_q   <= req_size;
               signed_q <= req_signed;
               load_q   <= req_load;
               store_q  <= req_store;
               wdata_q  <= req_wdata;
            end
         end else if (in_access && !mem_ack) begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

   // Memory port is decoded from state so reset drops it immediately.
   assign req_ready = (state_q == IDLE) && !rst;
   assign mem_req   = in_access;
   assign mem_addr  = in_access ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
   assign mem_we    = in_access && store_q;

   always_comb begin
      mem_wstrb = 4'h0;
      mem_wdata = 32'd0;
      if (in_access && store_q) begin
         case (size_q)
            2'd0: begin
               mem_wstrb = 4'b0001 << addr_q[1:0];
               mem_wdata = {4{wdata_q[7:0]}};
            end
            2'd1: begin
               mem_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
               mem_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
               mem_wstrb = 4'hF;
               mem_wdata = wdata_q;
            end
         endcase
      end
   end

   assign resp_valid = (state_q == RESP);
   assign resp_data  = resp_data_q;
   assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_lisa_lsu_hs.sv
// tb/tb_lisa_lsu_hs.sv - self-checking bench for lisa_lsu_hs
module tb_lisa_lsu_hs;

   localparam int AW = 16;
   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_load, req_store, req_signed;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_data;
   logic        mem_req, mem_we, mem_ack;
   logic [AW-1:0] mem_addr;
   logic [31:0] mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   lisa_lsu_hs #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_load(req_load), .req_store(req_store),
      .req_size(req_size), .req_signed(req_signed),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   // Reference model: access width in bytes and arithmetic lane handling.
   function automatic logic [31:0] model_load(logic [1:0] sz, logic sg,
                                              logic [31:0] ad, logic [31:0] rd);
      int nb;
      logic [63:0] v, mask;
      nb   = 1 << sz;
      v    = {32'd0, rd} >> (8 * (ad % 4));
      mask = (64'd1 << (8 * nb)) - 64'd1;
      v    = v & mask;
      if (sg && nb < 4 && v[8*nb-1]) v = v | ~mask;
      return v[31:0];
   endfunction

   function automatic logic [31:0] model_wdata(logic [1:0] sz, logic [31:0] wd);
      int nb;
      logic [31:0] w;
      nb = 1 << sz;
      for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % nb) +: 8];
      return w;
   endfunction

   task automatic do_txn(input string nm, input logic ld, input logic st,
                         input logic [1:0] sz, input logic sg,
                         input logic [31:0] ad, input logic [31:0] wd,
                         input logic [31:0] rd, input int ack_at, input bit noise);
      int nb, cyc, exp_cyc;
      bit is_err, no_mem, timed_out;
      logic [31:0] exp_data, exp_wd;
      logic [3:0]  exp_strb;
      logic [AW-1:0] exp_addr;
      nb        = 1 << sz;
      is_err    = (sz == 2'd3) || (ld && st) || (sz != 2'd3 && (ad % nb) != 0);
      no_mem    = is_err || (!ld && !st);
      timed_out = !no_mem && !(ack_at >= 1 && ack_at <= TO);
      exp_cyc   = no_mem ? 0 : (timed_out ? TO : ack_at);
      exp_strb  = (st && sz != 2'd3) ? 4'(((1 << nb) - 1) << (ad % 4)) : 4'h0;
      exp_wd    = model_wdata(sz, wd);
      exp_addr  = AW'(ad) & ~AW'(3);
      exp_data  = (no_mem || timed_out || !ld) ? 32'd0 : model_load(sz, sg, ad, rd);

      total++;
      if (req_ready !== 1'b1) begin
         bad++; $display("FAIL %s ready_before: got %b exp 1", nm, req_ready);
      end
      req_valid = 1'b1; req_load = ld; req_store = st; req_size = sz;
      req_signed = sg; req_addr = ad; req_wdata = wd;
      @(negedge clk);
      if (!noise) req_valid = 1'b0;
      cyc = 0;
      while (resp_valid !== 1'b1 && cyc < 12) begin
         total++;
         if ({mem_req, mem_addr, mem_we, mem_wstrb, req_ready} !==
             {1'b1, exp_addr, st, exp_strb, 1'b0}) begin
            bad++;
            $display("FAIL %s mem_port c%0d: got req=%b addr=%h we=%b strb=%h rdy=%b exp req=1 addr=%h we=%b strb=%h rdy=0",
                     nm, cyc, mem_req, mem_addr, mem_we, mem_wstrb, req_ready,
                     exp_addr, st, exp_strb);
         end
         if (st) begin
            total++;
            if (mem_wdata !== exp_wd) begin
               bad++; $display("FAIL %s mem_wdata: got %h exp %h", nm, mem_wdata, exp_wd);
            end
         end
         if (noise) begin
            req_load = 1'($urandom); req_store = 1'($urandom);
            req_size = 2'($urandom); req_addr = $urandom; req_wdata = $urandom;
         end
         cyc++;
         mem_rdata = $urandom;
         if (cyc == ack_at) begin mem_ack = 1'b1; mem_rdata = rd; end
         @(negedge clk);
         mem_ack = 1'b0;
      end
      req_valid = 1'b0;
      total++;
      if ({resp_valid, resp_err, resp_data, mem_req} !== {1'b1, is_err || timed_out, exp_data, 1'b0}) begin
         bad++;
         $display("FAIL %s resp: got v=%b err=%b data=%h mreq=%b exp v=1 err=%b data=%h mreq=0",
                  nm, resp_valid, resp_err, resp_data, mem_req, is_err || timed_out, exp_data);
      end
      total++;
      if (cyc !== exp_cyc) begin
         bad++; $display("FAIL %s latency: got %0d exp %0d", nm, cyc, exp_cyc);
      end
      @(negedge clk);
      total++;
      if ({resp_valid, resp_err, resp_data, req_ready} !== {1'b0, 1'b0, 32'd0, 1'b1}) begin
         bad++;
         $display("FAIL %s after_resp: got v=%b err=%b data=%h rdy=%b exp 0 0 0 1",
                  nm, resp_valid, resp_err, resp_data, req_ready);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 0; req_load = 0; req_store = 0; req_size = 0;
      req_signed = 0; req_addr = 0; req_wdata = 0; mem_ack = 0; mem_rdata = 0;
      repeat (2) @(negedge clk);
      total++;
      if ({req_ready, resp_valid, resp_err, resp_data, mem_req, mem_addr, mem_we, mem_wstrb} !== '0) begin
         bad++; $display("FAIL reset_outputs: got rdy=%b v=%b mreq=%b addr=%h exp all 0",
                         req_ready, resp_valid, mem_req, mem_addr);
      end
      rst = 1'b0;
      #1;
      total++;
      if (req_ready !== 1'b1) begin
         bad++; $display("FAIL reset_release_ready: got %b exp 1", req_ready);
      end
   endtask

   task automatic test_word_store();
      do_txn("word_store", 0, 1, 2'd2, 0, 32'h0000_1234, 32'hDEADBEEF, 32'h0, 2, 0);
   endtask

   task automatic test_loads();
      do_txn("lb_s", 1, 0, 2'd0, 1, 32'h13, 32'h0, 32'h80FF_7F01, 1, 0);
      do_txn("lb_u", 1, 0, 2'd0, 0, 32'h13, 32'h0, 32'h80FF_7F01, 3, 0);
      do_txn("lh_s", 1, 0, 2'd1, 1, 32'h12, 32'h0, 32'h80FF_7F01, 2, 0);
      do_txn("lh_u0", 1, 0, 2'd1, 0, 32'h10, 32'h0, 32'h80FF_8F01, 1, 0);
      do_txn("lw", 1, 0, 2'd2, 1, 32'h10, 32'h0, 32'h80FF_7F01, 1, 0);
   endtask

   task automatic test_narrow_stores();
      do_txn("sb", 0, 1, 2'd0, 0, 32'h2, 32'h0000_00AB, 32'h0, 1, 0);
      do_txn("sh", 0, 1, 2'd1, 0, 32'h2, 32'h0000_1234, 32'h0, 1, 0);
   endtask

   task automatic test_errors();
      do_txn("err_half", 1, 0, 2'd1, 0, 32'h1, 32'h0, 32'h0, 1, 0);
      do_txn("err_word", 0, 1, 2'd2, 0, 32'h2, 32'h5, 32'h0, 1, 0);
      do_txn("err_size3", 1, 0, 2'd3, 0, 32'h0, 32'h0, 32'h0, 1, 0);
      do_txn("err_both", 1, 1, 2'd2, 0, 32'h4, 32'h0, 32'h0, 1, 0);
      do_txn("noop", 0, 0, 2'd2, 0, 32'h8, 32'h0, 32'h0, 1, 0);
   endtask

   task automatic test_timeout();
      do_txn("to_noack", 1, 0, 2'd2, 0, 32'h20, 32'h0, 32'h1111_2222, 0, 0);
      do_txn("to_ack_last", 1, 0, 2'd2, 0, 32'h20, 32'h0, 32'h1111_2222, TO, 0);
      do_txn("to_store", 0, 1, 2'd0, 0, 32'h23, 32'h77, 32'h0, 0, 0);
   endtask

   task automatic test_ignored_inputs();
      mem_ack = 1'b1;
      repeat (2) begin
         @(negedge clk);
         total++;
         if ({resp_valid, mem_req, req_ready} !== 3'b001) begin
            bad++; $display("FAIL idle_ack: got v=%b mreq=%b rdy=%b exp 0 0 1",
                            resp_valid, mem_req, req_ready);
         end
      end
      mem_ack = 1'b0;
      do_txn("busy_noise", 1, 0, 2'd1, 1, 32'h46, 32'h0, 32'h9ABC_0000, 3, 1);
      do_txn("err_noise", 1, 1, 2'd0, 0, 32'h46, 32'h0, 32'h0, 1, 1);
   endtask

   task automatic test_reset_mid_access();
      req_valid = 1'b1; req_load = 1'b1; req_store = 1'b0; req_size = 2'd2;
      req_addr = 32'h40; req_signed = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      total++;
      if ({mem_req, req_ready, resp_valid} !== 3'b000) begin
         bad++; $display("FAIL rst_mid: got mreq=%b rdy=%b v=%b exp 0 0 0",
                         mem_req, req_ready, resp_valid);
      end
      @(negedge clk);
      rst = 1'b0;
      mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total++;
         if ({resp_valid, mem_req, req_ready} !== 3'b001) begin
            bad++; $display("FAIL rst_stale c%0d: got v=%b mreq=%b rdy=%b exp 0 0 1",
                            i, resp_valid, mem_req, req_ready);
         end
      end
      mem_ack = 1'b0;
      do_txn("post_rst", 1, 0, 2'd2, 0, 32'h44, 32'h0, 32'h1234_5678, 1, 0);
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 40; n++) begin
         logic ld, st, sg;
         logic [1:0] sz;
         logic [31:0] ad;
         int r;
         r = $urandom_range(0, 9);
         ld = (r == 0) || (r >= 2 && r <= 5);
         st = (r == 0) || (r >= 6);
         sz = 2'($urandom_range(0, 3));
         sg = 1'($urandom);
         ad = $urandom;
         if (sz != 2'd3 && $urandom_range(0, 2) != 0) ad = ad & ~((32'd1 << sz) - 32'd1);
         do_txn("rand", ld, st, sz, sg, ad, $urandom, $urandom,
                $urandom_range(1, TO + 1), 1'($urandom_range(0, 3) == 0));
      end
   endtask

   initial begin
      test_reset();
      test_word_store();
      test_loads();
      test_narrow_stores();
      test_errors();
      test_timeout();
      test_ignored_inputs();
      test_reset_mid_access();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
